// File: rtl/cursor_ctrl.sv
// -----------------------------------------------------------------------------
// cursor_ctrl
// Board cursor / square-selection controller driven by five raw push keys.
// Each key is synchronized, debounced and edge-detected into a one-cycle press.
// Presses move the cursor around an 8x8 board with saturation at the edges.
// A select press commits the current cursor square to select_loc. A change of
// the side to move reloads the cursor with that side's home square. Once
// either side wins, the block locks up until reset.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   btn_up/down/left/right/sel  raw active-high keys, asynchronous to clk
//   turn          side to move (1 = red)
//   red_win, white_win  game-over flags
//   cursor_loc    highlighted square {x[2:0], y[2:0]}
//   select_loc    last committed square {x, y}
//   commit        one-cycle pulse in the cycle select_loc takes a new value
//   idle_timeout  level, no accepted press for TIMEOUT cycles (RUN only)
//   locked        level, game over; this is also the FSM state (LOCK)
// -----------------------------------------------------------------------------
module cursor_ctrl #(
    parameter int DB_CYCLES = 4,
    parameter int TIMEOUT   = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_sel,
    input  logic       turn,
    input  logic       red_win,
    input  logic       white_win,
    output logic [5:0] cursor_loc,
    output logic [5:0] select_loc,
    output logic       commit,
    output logic       idle_timeout,
    output logic       locked
);

    localparam int         NB         = 5;
    localparam logic [7:0] DB_LAST    = 8'(DB_CYCLES - 1);
    localparam logic [19:0] TO_VAL    = 20'(TIMEOUT);
    localparam logic [5:0] HOME_RED   = {3'd3, 3'd2};
    localparam logic [5:0] HOME_WHITE = {3'd4, 3'd5};

    typedef enum logic {
        RUN  = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t state;

    // Bit order used for every per-key vector: {up, down, left, right, sel}.
    logic [NB-1:0] raw;
    logic [NB-1:0] sync1, sync2;
    logic [NB-1:0] db_level, db_prev, armed;
    logic [7:0]    db_cnt [NB];
    logic [1:0]    warm;
    logic [NB-1:0] press;

    assign raw = {btn_up, btn_down, btn_left, btn_right, btn_sel};

    // Two-flop synchronizer. warm[1] goes high once sync2 holds a real sample
    // rather than its reset value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
            warm  <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            warm  <= {warm[0], 1'b1};
        end
    end

    // Per-key debouncer. The accepted level flips only after DB_CYCLES
    // consecutive synchronized samples disagree with it. A key is armed only
    // after it has been seen low with valid samples, so a key held through
    // reset cannot generate a press until it is released and pressed again.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_level <= '0;
            db_prev  <= '0;
            armed    <= '0;
            for (int i = 0; i < NB; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            db_prev <= db_level;
            for (int i = 0; i < NB; i++) begin
                if (warm[1] && !sync2[i]) begin
                    armed[i] <= 1'b1;
                end
                if (sync2[i] != db_level[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        db_level[i] <= sync2[i];
                        db_cnt[i]   <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 8'd1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // One-cycle press on a rising debounced level.
    assign press = db_level & ~db_prev & armed;

    logic        p_up, p_down, p_left, p_right, p_sel;
    logic [2:0]  cur_x, cur_y, nxt_x, nxt_y;
    logic        turn_q, turn_chg;
    logic [19:0] idle_cnt, idle_nxt;

    assign {p_up, p_down, p_left, p_right, p_sel} = press;

    // Saturating moves; opposing presses on one axis cancel.
    always_comb begin
        cur_x = cursor_loc[5:3];
        cur_y = cursor_loc[2:0];
        nxt_x = cur_x;
        nxt_y = cur_y;
        if (p_right && !p_left && cur_x != 3'd7) begin
            nxt_x = cur_x + 3'd1;
        end else if (p_left && !p_right && cur_x != 3'd0) begin
            nxt_x = cur_x - 3'd1;
        end
        if (p_up && !p_down && cur_y != 3'd7) begin
            nxt_y = cur_y + 3'd1;
        end else if (p_down && !p_up && cur_y != 3'd0) begin
            nxt_y = cur_y - 3'd1;
        end
        turn_chg = (turn != turn_q);
        if ((|press) || turn_chg) begin
            idle_nxt = '0;
        end else if (idle_cnt == TO_VAL) begin
            idle_nxt = idle_cnt;
        end else begin
            idle_nxt = idle_cnt + 20'd1;
        end
    end

    // Main FSM. A win flag seen at an edge takes priority over everything
    // else on that edge, so a press accepted on the same edge is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= RUN;
            cursor_loc   <= HOME_RED;
            select_loc   <= {3'd0, 3'd1};
            commit       <= 1'b0;
            idle_timeout <= 1'b0;
            locked       <= 1'b0;
            turn_q       <= 1'b1;
            idle_cnt     <= '0;
        end else begin
            turn_q <= turn;
            case (state)
                RUN: begin
                    if (red_win || white_win) begin
                        state        <= LOCK;
                        locked       <= 1'b1;
                        commit       <= 1'b0;
                        idle_timeout <= 1'b0;
                        idle_cnt     <= '0;
                    end else begin
                        commit <= p_sel;
                        // Select captures the cursor as it was before this edge.
                        if (p_sel) begin
                            select_loc <= cursor_loc;
                        end
                        // Home load wins over any move on the same edge.
                        if (turn_chg) begin
                            cursor_loc <= turn ? HOME_RED : HOME_WHITE;
                        end else begin
                            cursor_loc <= {nxt_x, nxt_y};
                        end
                        idle_cnt     <= idle_nxt;
                        idle_timeout <= (idle_nxt == TO_VAL);
                    end
                end
                default: begin
                    locked       <= 1'b1;
                    commit       <= 1'b0;
                    idle_timeout <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cursor_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cursor_ctrl
// Self-checking bench for cursor_ctrl. A reference model applies each key
// transaction at the level of board squares and pushes the expected output
// tuples {locked, commit, select_loc, cursor_loc} into exp_q. A monitor pops
// and compares every time the DUT outputs change. idle_timeout and reset
// values are checked at fixed points.
// -----------------------------------------------------------------------------
module tb_cursor_ctrl;

    localparam int DB        = 4;
    localparam int TO        = 8;
    // Raw key to press-pulse cycle: two synchronizer stages plus DB samples.
    localparam int PRESS_LAT = DB + 2;

    localparam logic [4:0] K_UP    = 5'b10000;
    localparam logic [4:0] K_DOWN  = 5'b01000;
    localparam logic [4:0] K_LEFT  = 5'b00100;
    localparam logic [4:0] K_RIGHT = 5'b00010;
    localparam logic [4:0] K_SEL   = 5'b00001;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0;
    logic       btn_right = 1'b0, btn_sel = 1'b0;
    logic       turn = 1'b1, red_win = 1'b0, white_win = 1'b0;
    logic [5:0] cursor_loc, select_loc;
    logic       commit, idle_timeout, locked;

    cursor_ctrl #(.DB_CYCLES(DB), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .btn_sel      (btn_sel),
        .turn         (turn),
        .red_win      (red_win),
        .white_win    (white_win),
        .cursor_loc   (cursor_loc),
        .select_loc   (select_loc),
        .commit       (commit),
        .idle_timeout (idle_timeout),
        .locked       (locked)
    );

    // ---------------- scoreboard ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [13:0] exp_q[$];
    bit          mon_en  = 1'b0;
    logic [13:0] mon_last;
    wire  [13:0] dut_t = {locked, commit, select_loc, cursor_loc};

    task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && dut_t !== mon_last) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_change: got %h expected no change at %0t", dut_t, $time);
            end else begin
                check("output_change", dut_t, exp_q.pop_front());
            end
            mon_last = dut_t;
        end
    end

    // ---------------- reference model ----------------
    int          mx, my, msx, msy;
    bit          m_locked;
    logic        m_turn;
    logic [13:0] m_last;

    function automatic logic [13:0] tup(bit lk, bit cm, int sx, int sy, int cx, int cy);
        return {lk, cm, 3'(sx), 3'(sy), 3'(cx), 3'(cy)};
    endfunction

    function automatic int clamp7(int v);
        return (v < 0) ? 0 : ((v > 7) ? 7 : v);
    endfunction

    task automatic push_exp(input logic [13:0] t);
        if (t != m_last) begin
            exp_q.push_back(t);
            m_last = t;
        end
    endtask

    task automatic model_reset();
        mx = 3; my = 2; msx = 0; msy = 1;
        m_locked = 1'b0;
        m_turn   = 1'b1;
        m_last   = tup(0, 0, 0, 1, 3, 2);
    endtask

    task automatic model_home();
        if (m_turn) begin mx = 3; my = 2; end
        else        begin mx = 4; my = 5; end
    endtask

    // One accepted press set, optionally coinciding with a turn change or a win.
    task automatic model_press(input logic [4:0] m, input bit turn_same, input bit win_same);
        bit s;
        if (turn_same) m_turn = ~m_turn;
        if (m_locked) return;
        if (win_same) begin
            m_locked = 1'b1;
            push_exp(tup(1, 0, msx, msy, mx, my));
            return;
        end
        s = m[0];
        if (s) begin msx = mx; msy = my; end
        if (turn_same) begin
            model_home();
        end else begin
            mx = clamp7(mx + int'(m[1]) - int'(m[2]));
            my = clamp7(my + int'(m[4]) - int'(m[3]));
        end
        push_exp(tup(0, s, msx, msy, mx, my));
        if (s) push_exp(tup(0, 0, msx, msy, mx, my));
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_keys(input logic [4:0] m);
        {btn_up, btn_down, btn_left, btn_right, btn_sel} = m;
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; turn = 1'b1; red_win = 1'b0; white_win = 1'b0;
        #1;
        check("reset_outputs", dut_t, tup(0, 0, 0, 1, 3, 2));
        check("reset_idle", {13'd0, idle_timeout}, 14'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        model_reset();
        exp_q.delete();
        mon_last = m_last;
        mon_en = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic press(input logic [4:0] m, input int hold);
        model_press(m, 1'b0, 1'b0);
        @(posedge clk); #1 set_keys(m);
        repeat (hold) @(posedge clk);
        #1 set_keys(5'd0);
        repeat (DB + 6) @(posedge clk);
    endtask

    // Keys held too briefly to pass the debouncer.
    task automatic glitch(input logic [4:0] m, input int hold);
        @(posedge clk); #1 set_keys(m);
        repeat (hold) @(posedge clk);
        #1 set_keys(5'd0);
        repeat (DB + 6) @(posedge clk);
    endtask

    task automatic toggle_turn();
        m_turn = ~m_turn;
        if (!m_locked) begin
            model_home();
            push_exp(tup(0, 0, msx, msy, mx, my));
        end
        @(posedge clk); #1 turn = ~turn;
        repeat (3) @(posedge clk);
    endtask

    // Press with a turn change and/or win flag landing in the press-pulse cycle.
    task automatic press_with(input logic [4:0] m, input bit do_turn, input bit do_win);
        model_press(m, do_turn, do_win);
        @(posedge clk); #1 set_keys(m);
        repeat (PRESS_LAT) @(posedge clk);
        #1;
        if (do_turn) turn = ~turn;
        if (do_win) white_win = 1'b1;
        @(posedge clk); #1 white_win = 1'b0;
        repeat (DB) @(posedge clk);
        #1 set_keys(5'd0);
        repeat (DB + 6) @(posedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        do_reset();

        // Single held key gives one move.
        press(K_RIGHT, 10);
        // Walk to (7,0), then corner saturation and diagonal step.
        repeat (3) press(K_RIGHT, 5);
        repeat (2) press(K_DOWN, 5);
        press(K_RIGHT | K_DOWN, 6);
        press(K_UP | K_LEFT, 6);

        // Walk to (2,3) and commit it.
        repeat (4) press(K_LEFT, 5);
        repeat (2) press(K_UP, 5);
        press(K_SEL, 6);
        check("sel_value", {8'd0, select_loc}, 14'b00_0000_0001_0011);
        press(K_UP, 5);
        check("sel_hold", {8'd0, select_loc}, 14'b00_0000_0001_0011);

        // To (1,1), then select + up with a turn change on the same edge.
        press(K_LEFT, 5);
        repeat (3) press(K_DOWN, 5);
        press_with(K_UP | K_SEL, 1'b1, 1'b0);
        check("turn_home", {8'd0, cursor_loc}, 14'b00_0000_0010_0101);
        check("turn_sel", {8'd0, select_loc}, 14'b00_0000_0000_1001);

        // Idle timeout, counted from the turn-change edge.
        toggle_turn_timed();

        // Randomized transactions.
        for (int k = 0; k < 40; k++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 5)      press(5'($urandom_range(1, 31)), $urandom_range(DB, DB + 6));
            else if (r <= 7) glitch(5'($urandom_range(1, 31)), $urandom_range(1, DB - 1));
            else             toggle_turn();
        end

        // Key held across reset must not produce a press.
        @(posedge clk); #1 set_keys(K_UP);
        repeat (2) @(posedge clk);
        do_reset();
        repeat (10) @(posedge clk);
        #1 set_keys(5'd0);
        repeat (DB + 6) @(posedge clk);
        press(K_UP, 6);

        // Win on the same edge as a press; then everything frozen.
        press_with(K_UP, 1'b0, 1'b1);
        press(K_RIGHT, 6);
        toggle_turn();
        press(K_SEL, 6);
        repeat (20) @(posedge clk);
        #1;
        check("lock_idle", {13'd0, idle_timeout}, 14'd0);
        check("lock_level", {13'd0, locked}, 14'd1);

        do_reset();
        press(K_RIGHT, 6);
        repeat (5) @(posedge clk);

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL exp_q_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    task automatic toggle_turn_timed();
        m_turn = ~m_turn;
        model_home();
        push_exp(tup(0, 0, msx, msy, mx, my));
        @(posedge clk); #1 turn = ~turn;
        repeat (8) @(posedge clk);
        #1 check("idle_before_to", {13'd0, idle_timeout}, 14'd0);
        @(posedge clk);
        #1 check("idle_at_to", {13'd0, idle_timeout}, 14'd1);
        repeat (3) @(posedge clk);
        #1 check("idle_sat", {13'd0, idle_timeout}, 14'd1);
        model_press(K_LEFT, 1'b0, 1'b0);
        set_keys(K_LEFT);
        repeat (PRESS_LAT) @(posedge clk);
        #1 check("idle_in_pulse", {13'd0, idle_timeout}, 14'd1);
        @(posedge clk);
        #1 check("idle_after_press", {13'd0, idle_timeout}, 14'd0);
        repeat (2) @(posedge clk);
        #1 set_keys(5'd0);
        repeat (DB + 6) @(posedge clk);
    endtask

endmodule
